mem_access_stage: RTL and testbench

Memory-access stage of the pipelined ARM processor. Sits between the EX/MEM pipeline register and the register-file write port of `id_stage`. Performs byte/word loads and stores against a 256-byte data memory and selects the write-back value. Holds the MEM/WB pipeline register that drives write-back and the forwarding path.

---
 rtl/ppu_pkg.sv | 52 +++++
 rtl/mem_access_stage_data_ram.sv | 69 ++++++
 rtl/mem_access_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_pkg
//  Description : Shared encodings, sizes and the MEM/WB pipeline record used
//                by the memory-access stage and its data RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

   // Access size encoding carried on ex_mem_size
   localparam logic MEM_SIZE_BYTE = 1'b0;
   localparam logic MEM_SIZE_WORD = 1'b1;

   // Direction encoding carried on ex_mem_rw
   localparam logic MEM_RW_LOAD   = 1'b0;
   localparam logic MEM_RW_STORE  = 1'b1;

   // Data memory depth in bytes
   localparam int   DMEM_DEPTH    = 256;

   // MEM/WB pipeline record: write-back value, destination register, strobe.
   // The register field cannot be called "reg" (keyword), hence regnum.
   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  regnum;
      logic        we;
   } mem_wb_t;

   // One-hot byte-lane mask for a byte offset inside a word.
   // Bit i selects byte offset i, i.e. offset 0 is the most significant byte.
   function automatic logic [3:0] byte_lane_mask(input logic [1:0] offset);
      logic [3:0] mask;
      mask         = 4'b0000;
      mask[offset] = 1'b1;
      return mask;
   endfunction

   // Extract the byte at a given offset from a big-endian word.
   function automatic logic [7:0] be_byte_select(input logic [31:0] word,
                                                 input logic [1:0]  offset);
      logic [7:0] sel;
      case (offset)
         2'd0:    sel = word[31:24];
         2'd1:    sel = word[23:16];
         2'd2:    sel = word[15:8];
         default: sel = word[7:0];
      endcase
      return sel;
   endfunction

endpackage : ppu_pkg
`default_nettype wire

// File: rtl/mem_access_stage_data_ram.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram
//  Description : Byte-addressed data memory organised as 2^ADDR_W x 8.
//                Four byte lanes with individual write enables written on the
//                rising edge; asynchronous big-endian 32-bit word read.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_ram
   import ppu_pkg::*;
#(
   parameter int ADDR_W           = 8,
   parameter int RESET_CLEARS_MEM = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-3:0] i_word_addr,   // word index (byte address >> 2)
   input  logic [3:0]        i_be,          // bit i writes byte offset i
   input  logic [31:0]       i_wdata,       // big-endian lane data
   output logic [31:0]       o_rdata        // big-endian word at i_word_addr
);

   localparam int c_DEPTH = 1 << ADDR_W;

   // Array name is fixed so benches can reach it hierarchically
   logic [7:0] memory [0:c_DEPTH-1];

   // Asynchronous read: offset 0 supplies the most significant byte
   always_comb begin
      o_rdata = {memory[{i_word_addr, 2'd0}],
                 memory[{i_word_addr, 2'd1}],
                 memory[{i_word_addr, 2'd2}],
                 memory[{i_word_addr, 2'd3}]};
   end

   generate
      if (RESET_CLEARS_MEM != 0) begin : g_clear
         // Byte-lane write; reset wipes the whole array
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < c_DEPTH; i++) begin
                  memory[i] <= 8'h00;
               end
            end else begin
               for (int i = 0; i < 4; i++) begin
                  if (i_be[i]) begin
                     memory[{i_word_addr, 2'(i)}] <= i_wdata[31-8*i -: 8];
                  end
               end
            end
         end
      end else begin : g_keep
         // Contents survive reset; the caller already masks writes during reset
         logic w_unused_reset;
         assign w_unused_reset = reset;

         // Byte-lane write
         always_ff @(posedge clk) begin
            for (int i = 0; i < 4; i++) begin
               if (i_be[i]) begin
                  memory[{i_word_addr, 2'(i)}] <= i_wdata[31-8*i -: 8];
               end
            end
         end
      end
   endgenerate

endmodule : data_ram
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : Memory-access stage of the pipelined ARM core. Performs
//                byte/word big-endian loads and stores, selects the
//                write-back value and holds the MEM/WB pipeline register.
//                Misaligned word accesses raise a sticky alignment flag;
//                misaligned word stores are dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
   import ppu_pkg::*;
#(
   parameter int ADDR_W           = 8,
   parameter int RESET_CLEARS_MEM = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       ex_alu_result,
   input  logic [31:0]       ex_store_data,
   input  logic [3:0]        ex_write_reg,
   input  logic              ex_reg_write_enable,
   input  logic              ex_mem_enable,
   input  logic              ex_mem_rw,
   input  logic              ex_mem_size,
   input  logic              ex_mem_to_reg_select,
   output logic [31:0]       mem_result,
   output logic [31:0]       wb_write_data,
   output logic [3:0]        wb_write_reg,
   output logic              wb_write_enable,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_write_data,
   output logic              align_error
);

   // ------------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------------
   logic [ADDR_W-1:0] w_addr;
   logic [1:0]        w_offset;
   logic              w_is_word;
   logic              w_is_store;
   logic              w_misaligned;
   logic              w_unused_addr_hi;

   // Upper address bits are dropped so accesses wrap around the array
   assign w_addr           = ex_alu_result[ADDR_W-1:0];
   assign w_unused_addr_hi = ^ex_alu_result[31:ADDR_W];
   assign w_offset         = w_addr[1:0];
   assign w_is_word        = (ex_mem_size == MEM_SIZE_WORD);
   assign w_is_store       = ex_mem_enable && (ex_mem_rw == MEM_RW_STORE);
   assign w_misaligned     = ex_mem_enable && w_is_word && (w_offset != 2'b00);

   // ------------------------------------------------------------------------
   // Store lane generation
   // ------------------------------------------------------------------------
   logic [3:0]  w_be;
   logic [31:0] w_wdata;

   // Pick byte enables and lane data; reset and misaligned words write nothing
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = ex_store_data;
      if (w_is_store && !reset) begin
         if (w_is_word) begin
            if (!w_misaligned) begin
               w_be = 4'b1111;
            end
         end else begin
            w_be    = byte_lane_mask(w_offset);
            w_wdata = {4{ex_store_data[7:0]}};
         end
      end
   end

   // ------------------------------------------------------------------------
   // Data memory
   // ------------------------------------------------------------------------
   logic [31:0] w_rdata;

   data_ram #(
      .ADDR_W           (ADDR_W),
      .RESET_CLEARS_MEM (RESET_CLEARS_MEM)
   ) u_ram (
      .clk         (clk),
      .reset       (reset),
      .i_word_addr (w_addr[ADDR_W-1:2]),
      .i_be        (w_be),
      .i_wdata     (w_wdata),
      .o_rdata     (w_rdata)
   );

   // ------------------------------------------------------------------------
   // Load formatting and result selection
   // ------------------------------------------------------------------------
   logic [31:0] w_load_data;
   logic        w_reg_we_q;
   mem_wb_t     w_mem_wb_next;

   // Word loads return the aligned word; byte loads zero-extend one lane
   always_comb begin
      w_load_data = w_rdata;
      if (!w_is_word) begin
         w_load_data = {24'h000000, be_byte_select(w_rdata, w_offset)};
      end
   end

   // Forwarding result: load data only for memory instructions asking for it
   always_comb begin
      mem_result = ex_alu_result;
      if (ex_mem_enable && ex_mem_to_reg_select) begin
         mem_result = w_load_data;
      end
   end

   // A store never writes the register file, whatever EX requested
   assign w_reg_we_q = ex_reg_write_enable && !w_is_store;

   // Next MEM/WB record
   always_comb begin
      w_mem_wb_next        = '0;
      w_mem_wb_next.data   = mem_result;
      w_mem_wb_next.regnum = ex_write_reg;
      w_mem_wb_next.we     = w_reg_we_q;
   end

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   mem_wb_t r_mem_wb;
   logic    r_align_error;

   // MEM/WB pipeline register, loaded every cycle (no stall path)
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_wb <= '0;
      end else begin
         r_mem_wb <= w_mem_wb_next;
      end
   end

   // Sticky misalignment flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_align_error <= 1'b0;
      end else if (w_misaligned) begin
         r_align_error <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign wb_write_data   = r_mem_wb.data;
   assign wb_write_reg    = r_mem_wb.regnum;
   assign wb_write_enable = r_mem_wb.we;
   assign align_error     = r_align_error;
   assign mem_address     = w_addr;
   assign mem_write_data  = ex_store_data;

endmodule : mem_access_stage
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Directed self-checking bench for mem_access_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

   logic        clk;
   logic        reset;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_store_data;
   logic [3:0]  ex_write_reg;
   logic        ex_reg_write_enable;
   logic        ex_mem_enable;
   logic        ex_mem_rw;
   logic        ex_mem_size;
   logic        ex_mem_to_reg_select;
   logic [31:0] mem_result;
   logic [31:0] wb_write_data;
   logic [3:0]  wb_write_reg;
   logic        wb_write_enable;
   logic [7:0]  mem_address;
   logic [31:0] mem_write_data;
   logic        align_error;

   int checks = 0;
   int errors = 0;

   mem_access_stage #(
      .ADDR_W           (8),
      .RESET_CLEARS_MEM (0)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .ex_alu_result        (ex_alu_result),
      .ex_store_data        (ex_store_data),
      .ex_write_reg         (ex_write_reg),
      .ex_reg_write_enable  (ex_reg_write_enable),
      .ex_mem_enable        (ex_mem_enable),
      .ex_mem_rw            (ex_mem_rw),
      .ex_mem_size          (ex_mem_size),
      .ex_mem_to_reg_select (ex_mem_to_reg_select),
      .mem_result           (mem_result),
      .wb_write_data        (wb_write_data),
      .wb_write_reg         (wb_write_reg),
      .wb_write_enable      (wb_write_enable),
      .mem_address          (mem_address),
      .mem_write_data       (mem_write_data),
      .align_error          (align_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its hand-computed expectation
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one instruction to the stage
   task automatic drive(input logic [31:0] alu, input logic [31:0] sd,
                        input logic [3:0] wreg, input logic we,
                        input logic men, input logic rw,
                        input logic size, input logic m2r);
      ex_alu_result        = alu;
      ex_store_data        = sd;
      ex_write_reg         = wreg;
      ex_reg_write_enable  = we;
      ex_mem_enable        = men;
      ex_mem_rw            = rw;
      ex_mem_size          = size;
      ex_mem_to_reg_select = m2r;
   endtask

   task automatic bubble();
      drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Advance one clock; leave time 1 unit past the edge for sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mem_word(input int a);
      return {dut.u_ram.memory[a], dut.u_ram.memory[a+1],
              dut.u_ram.memory[a+2], dut.u_ram.memory[a+3]};
   endfunction

   initial begin
      reset = 1'b1;
      bubble();
      step();
      step();
      chk("rst_wb_data", wb_write_data, 32'h0);
      chk("rst_wb_reg",  {28'h0, wb_write_reg}, 32'h0);
      chk("rst_wb_we",   {31'h0, wb_write_enable}, 32'h0);
      chk("rst_align",   {31'h0, align_error}, 32'h0);
      reset = 1'b0;

      // Preload mem[0..3] = 11 22 33 44 via an aligned word store (we=1 ignored)
      drive(32'h0, 32'h11223344, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      chk("st0_wb_we",   {31'h0, wb_write_enable}, 32'h0);
      chk("st0_mem",     mem_word(0), 32'h11223344);

      // Word load at 0: zero-latency result, registered one cycle later
      drive(32'h0, 32'h0, 4'h3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      chk("ld0_result",  mem_result, 32'h11223344);
      step();
      chk("ld0_wb_data", wb_write_data, 32'h11223344);
      chk("ld0_wb_reg",  {28'h0, wb_write_reg}, 32'h3);
      chk("ld0_wb_we",   {31'h0, wb_write_enable}, 32'h1);

      // mem[4..7] = 55 66 77 88, then byte store DD to address 5
      drive(32'h4, 32'h55667788, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      drive(32'h5, 32'hAABBCCDD, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      chk("stb5_mem",    mem_word(4), 32'h55DD7788);
      drive(32'h5, 32'h0, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      chk("ldb5_result", mem_result, 32'h000000DD);
      step();
      chk("ldb5_wb",     wb_write_data, 32'h000000DD);

      // Word store DEADBEEF at 8 with register write requested, then reload
      drive(32'h8, 32'hDEADBEEF, 4'h7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      chk("st8_wb_we",   {31'h0, wb_write_enable}, 32'h0);
      drive(32'h8, 32'h0, 4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      chk("ld8_result",  mem_result, 32'hDEADBEEF);
      chk("ld8_align",   {31'h0, align_error}, 32'h0);
      step();

      // Misaligned word store at 6: dropped, flag set
      drive(32'h6, 32'h12345678, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      chk("st6_mem",     mem_word(4), 32'h55DD7788);
      chk("st6_align",   {31'h0, align_error}, 32'h1);
      drive(32'h6, 32'h0, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      chk("ld6_result",  mem_result, 32'h55DD7788);
      step();
      bubble();
      step();
      step();
      chk("align_sticky", {31'h0, align_error}, 32'h1);

      // Address wrap: 0x103 reaches byte 3
      drive(32'h00000103, 32'h0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      chk("wrap_addr",   {24'h0, mem_address}, 32'h3);
      chk("wrap_result", mem_result, 32'h00000044);
      step();

      // No memory access: ALU result passes even with mem_to_reg set
      drive(32'hCAFE0000, 32'h0, 4'h9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      #1;
      chk("alu_pass",    mem_result, 32'hCAFE0000);
      step();
      chk("alu_wb",      wb_write_data, 32'hCAFE0000);

      // mem[12] = 5A, then a store during reset must not land
      drive(32'd12, 32'h0000005A, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      chk("st12_mem",    {24'h0, dut.u_ram.memory[12]}, 32'h5A);
      reset = 1'b1;
      drive(32'd12, 32'h000000EE, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      reset = 1'b0;
      bubble();
      chk("rst12_mem",   {24'h0, dut.u_ram.memory[12]}, 32'h5A);
      chk("rst_wb_data2", wb_write_data, 32'h0);
      chk("rst_wb_reg2", {28'h0, wb_write_reg}, 32'h0);
      chk("rst_wb_we2",  {31'h0, wb_write_enable}, 32'h0);
      chk("rst_align2",  {31'h0, align_error}, 32'h0);
      chk("rst_preload", mem_word(0), 32'h11223344);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_access_stage
`default_nettype wire
